alarm_responder: RTL and testbench

//  Peer end of the load/alarm handshake of the 3-state trigger FSM (idle -> load -> alarm).

---
 rtl/alarm_responder.sv | 149 ++++++++++++++
 tb/tb_alarm_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_responder.sv
// alarm_responder
//   Peer end of the load/alarm handshake of a 3-state trigger FSM
//   (idle -> load -> alarm). It watches the FSM's state levels and answers
//   with single-cycle trigger pulses that advance it.
//   - On a rising edge of m_load it captures preset_val and requests the
//     alarm phase with a trigger pulse.
//   - While m_alarm is high it counts the captured value down once every
//     PRESCALE cycles, toggling the buzzer on each tick. When the count is
//     exhausted it acknowledges with a second trigger pulse.
//
// Handshake: m_load/m_alarm are levels owned by the FSM, and trigger is a
//   one-cycle request/acknowledge pulse owned by this block. A request
//   (REQ) is issued only for a fresh m_load rise seen while idle. The
//   acknowledge (ACK) is issued only after the countdown completes. If the
//   FSM drops its level early (m_load in WAIT_AL, m_alarm in RING), that is
//   treated as a peer reset: the block returns to IDLE silently.
//
// Ports
//   m_clk        in   system clock, rising edge
//   m_reset      in   asynchronous active-high reset
//   m_load       in   high while FSM is in its load state
//   m_alarm      in   high while FSM is in its alarm state
//   preset_val   in   countdown value, sampled on m_load rise
//   trigger      out  one-cycle pulse to the FSM (high exactly in REQ / ACK)
//   buzzer       out  square wave, toggles per tick while ringing
//   count        out  remaining ticks
//   busy         out  high whenever state != IDLE
//   dbg_state_o  out  current FSM state encoding, for observation

module alarm_responder #(
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 50000
) (
    input  logic             m_clk,
    input  logic             m_reset,
    input  logic             m_load,
    input  logic             m_alarm,
    input  logic [CNT_W-1:0] preset_val,
    output logic             trigger,
    output logic             buzzer,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic [2:0]       dbg_state_o
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_AL  = 3'd2,
        RING     = 3'd3,
        ACK      = 3'd4,
        WAIT_CLR = 3'd5
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [PW-1:0]    presc_q;
    logic             buzzer_q;
    logic             trigger_q;
    logic             load_prev_q;

    always_ff @(posedge m_clk or posedge m_reset) begin
        if (m_reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            presc_q     <= '0;
            buzzer_q    <= 1'b0;
            trigger_q   <= 1'b0;
            load_prev_q <= 1'b0;
        end else begin
            load_prev_q <= m_load;
            // trigger is registered together with the state, so it is high
            // exactly while the state is REQ or ACK and never two cycles running.
            trigger_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    // Only a fresh rise counts; a level held over from a
                    // previous handshake does not start a new one.
                    if (m_load && !load_prev_q) begin
                        count_q   <= preset_val;
                        state_q   <= REQ;
                        trigger_q <= 1'b1;
                    end
                end

                REQ: begin
                    state_q <= WAIT_AL;
                end

                WAIT_AL: begin
                    if (m_alarm) begin
                        state_q <= RING;
                        presc_q <= '0;
                    end else if (!m_load) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end
                end

                RING: begin
                    if (!m_alarm) begin
                        state_q  <= IDLE;
                        buzzer_q <= 1'b0;
                        count_q  <= '0;
                    end else if (count_q == '0) begin
                        state_q   <= ACK;
                        trigger_q <= 1'b1;
                        buzzer_q  <= 1'b0;
                    end else if (presc_q == PRESC_MAX) begin
                        // Tick: first one lands PRESCALE cycles after entry.
                        presc_q  <= '0;
                        count_q  <= count_q - 1'b1;
                        buzzer_q <= ~buzzer_q;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end

                ACK: begin
                    buzzer_q <= 1'b0;
                    state_q  <= WAIT_CLR;
                end

                WAIT_CLR: begin
                    // m_load activity here is ignored; load_prev_q keeps
                    // tracking it so a level still high on return is no rise.
                    if (!m_alarm) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign trigger     = trigger_q;
    assign buzzer      = buzzer_q;
    assign count       = count_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alarm_responder.sv
module tb_alarm_responder;

  localparam int CNT_W    = 8;
  localparam int PRESCALE = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_WAIT_AL  = 3'd2;
  localparam logic [2:0] S_RING     = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_WAIT_CLR = 3'd5;

  logic             m_clk;
  logic             m_reset;
  logic             m_load;
  logic             m_alarm;
  logic [CNT_W-1:0] preset_val;
  logic             trigger;
  logic             buzzer;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic [2:0]       dbg_state;

  int checks;
  int errors;

  alarm_responder #(
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .m_clk       (m_clk),
    .m_reset     (m_reset),
    .m_load      (m_load),
    .m_alarm     (m_alarm),
    .preset_val  (preset_val),
    .trigger     (trigger),
    .buzzer      (buzzer),
    .count       (count),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  // advance one clock; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge m_clk);
    #1;
  endtask

  // Start a handshake from IDLE: raise m_load, check REQ pulse, reach WAIT_AL.
  task automatic start_load(input logic [CNT_W-1:0] pv, input string tag);
    preset_val = pv;
    m_load = 1'b1;
    step();
    checks++;
    if (trigger !== 1'b1 || count !== pv || busy !== 1'b1 || dbg_state !== S_REQ) begin
      errors++;
      $display("FAIL %s_req trig=%b count=%0d busy=%b st=%0d, need trig=1 count=%0d busy=1 st=%0d",
               tag, trigger, count, busy, dbg_state, pv, S_REQ);
    end
    step();
    checks++;
    if (trigger !== 1'b0 || dbg_state !== S_WAIT_AL) begin
      errors++;
      $display("FAIL %s_wait_al trig=%b st=%0d, need trig=0 st=%0d", tag, trigger, dbg_state, S_WAIT_AL);
    end
  endtask

  task automatic test_reset();
    m_reset = 1'b1;
    m_load = 1'b0;
    m_alarm = 1'b0;
    preset_val = '0;
    #12;
    checks++;
    if (trigger !== 1'b0 || buzzer !== 1'b0 || count !== '0 || busy !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state trig=%b buz=%b count=%0d busy=%b st=%0d, need all 0",
               trigger, buzzer, count, busy, dbg_state);
    end
    m_reset = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid_ring();
    start_load(8'd3, "rst_mid");
    m_alarm = 1'b1;
    m_load = 1'b0;
    step();
    step();
    checks++;
    if (dbg_state !== S_RING || count !== 8'd3) begin
      errors++;
      $display("FAIL rst_mid_ring st=%0d count=%0d, need st=%0d count=3", dbg_state, count, S_RING);
    end
    #2 m_reset = 1'b1;
    #1;
    checks++;
    if (trigger !== 1'b0 || buzzer !== 1'b0 || count !== '0 || busy !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL rst_mid_async trig=%b buz=%b count=%0d busy=%b st=%0d, need all 0",
               trigger, buzzer, count, busy, dbg_state);
    end
    m_alarm = 1'b0;
    #2 m_reset = 1'b0;
    step();
    start_load(8'd7, "rst_after");
    m_load = 1'b0;
    step();
    checks++;
    if (dbg_state !== S_IDLE || count !== '0) begin
      errors++;
      $display("FAIL rst_after_abort st=%0d count=%0d, need st=0 count=0", dbg_state, count);
    end
  endtask

  task automatic test_countdown();
    int exp_cnt;
    int exp_buz;
    int buz_toggles;
    logic prev_buz;
    start_load(8'd3, "cd");
    m_alarm = 1'b1;
    m_load = 1'b0;
    step();
    checks++;
    if (dbg_state !== S_RING || count !== 8'd3 || buzzer !== 1'b0 || trigger !== 1'b0) begin
      errors++;
      $display("FAIL cd_ring_entry st=%0d count=%0d buz=%b trig=%b, need st=3 count=3 buz=0 trig=0",
               dbg_state, count, buzzer, trigger);
    end
    buz_toggles = 0;
    prev_buz = buzzer;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_cnt = 3 - (k / 4);
      exp_buz = (k / 4) % 2;
      if (buzzer !== prev_buz) buz_toggles++;
      prev_buz = buzzer;
      checks++;
      if (count !== exp_cnt[CNT_W-1:0] || buzzer !== exp_buz[0] || trigger !== 1'b0) begin
        errors++;
        $display("FAIL cd_tick_%0d count=%0d buz=%b trig=%b, need count=%0d buz=%0d trig=0",
                 k, count, buzzer, trigger, exp_cnt, exp_buz);
      end
    end
    checks++;
    if (buz_toggles != 3) begin
      errors++;
      $display("FAIL cd_buz_toggles got=%0d need=3", buz_toggles);
    end
    step();
    checks++;
    if (trigger !== 1'b1 || dbg_state !== S_ACK || buzzer !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL cd_ack trig=%b st=%0d buz=%b count=%0d, need trig=1 st=%0d buz=0 count=0",
               trigger, dbg_state, buzzer, count, S_ACK);
    end
    step();
    checks++;
    if (trigger !== 1'b0 || dbg_state !== S_WAIT_CLR || busy !== 1'b1) begin
      errors++;
      $display("FAIL cd_wait_clr trig=%b st=%0d busy=%b, need trig=0 st=%0d busy=1",
               trigger, dbg_state, busy, S_WAIT_CLR);
    end
    step();
    checks++;
    if (dbg_state !== S_WAIT_CLR) begin
      errors++;
      $display("FAIL cd_hold_clr st=%0d need=%0d", dbg_state, S_WAIT_CLR);
    end
    m_alarm = 1'b0;
    step();
    checks++;
    if (dbg_state !== S_IDLE || busy !== 1'b0 || trigger !== 1'b0) begin
      errors++;
      $display("FAIL cd_idle st=%0d busy=%b trig=%b, need st=0 busy=0 trig=0", dbg_state, busy, trigger);
    end
  endtask

  task automatic test_preset_zero();
    start_load(8'd0, "z");
    m_alarm = 1'b1;
    m_load = 1'b0;
    step();
    checks++;
    if (dbg_state !== S_RING || trigger !== 1'b0 || buzzer !== 1'b0) begin
      errors++;
      $display("FAIL z_ring st=%0d trig=%b buz=%b, need st=3 trig=0 buz=0", dbg_state, trigger, buzzer);
    end
    step();
    checks++;
    if (trigger !== 1'b1 || dbg_state !== S_ACK || buzzer !== 1'b0) begin
      errors++;
      $display("FAIL z_ack trig=%b st=%0d buz=%b, need trig=1 st=%0d buz=0", trigger, dbg_state, buzzer, S_ACK);
    end
    m_alarm = 1'b0;
    step();
    step();
    checks++;
    if (dbg_state !== S_IDLE || trigger !== 1'b0) begin
      errors++;
      $display("FAIL z_idle st=%0d trig=%b, need st=0 trig=0", dbg_state, trigger);
    end
  endtask

  task automatic test_alarm_abort();
    int trig_seen;
    start_load(8'd5, "ab");
    m_alarm = 1'b1;
    m_load = 1'b0;
    step();
    for (int k = 1; k <= 12; k++) step();
    checks++;
    if (count !== 8'd2 || buzzer !== 1'b1) begin
      errors++;
      $display("FAIL ab_count2 count=%0d buz=%b, need count=2 buz=1", count, buzzer);
    end
    m_alarm = 1'b0;
    step();
    checks++;
    if (dbg_state !== S_IDLE || buzzer !== 1'b0 || count !== '0 || busy !== 1'b0 || trigger !== 1'b0) begin
      errors++;
      $display("FAIL ab_idle st=%0d buz=%b count=%0d busy=%b trig=%b, need all 0",
               dbg_state, buzzer, count, busy, trigger);
    end
    trig_seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (trigger === 1'b1) trig_seen++;
    end
    checks++;
    if (trig_seen != 0) begin
      errors++;
      $display("FAIL ab_no_ack trigger pulses=%0d need=0", trig_seen);
    end
  endtask

  task automatic test_load_drop();
    int trig_seen;
    start_load(8'd2, "ld");
    m_load = 1'b0;
    step();
    checks++;
    if (dbg_state !== S_IDLE || count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ld_idle st=%0d count=%0d busy=%b, need st=0 count=0 busy=0", dbg_state, count, busy);
    end
    trig_seen = 0;
    m_alarm = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (trigger === 1'b1) trig_seen++;
    end
    m_alarm = 1'b0;
    step();
    checks++;
    if (trig_seen != 0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL ld_no_trig pulses=%0d st=%0d, need pulses=0 st=0", trig_seen, dbg_state);
    end
  endtask

  task automatic test_held_load();
    int trig_seen;
    start_load(8'd1, "hl");
    m_alarm = 1'b1;
    step();
    for (int k = 0; k < 4; k++) step();
    step();
    checks++;
    if (trigger !== 1'b1 || dbg_state !== S_ACK) begin
      errors++;
      $display("FAIL hl_ack trig=%b st=%0d, need trig=1 st=%0d", trigger, dbg_state, S_ACK);
    end
    // fresh m_load rise during WAIT_CLR must be ignored
    step();
    m_load = 1'b0;
    step();
    m_load = 1'b1;
    step();
    m_alarm = 1'b0;
    step();
    trig_seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (trigger === 1'b1) trig_seen++;
    end
    checks++;
    if (trig_seen != 0 || dbg_state !== S_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL hl_no_req pulses=%0d st=%0d busy=%b, need pulses=0 st=0 busy=0",
               trig_seen, dbg_state, busy);
    end
    m_load = 1'b0;
    step();
    start_load(8'd9, "hl2");
    m_load = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid_ring();
    test_countdown();
    test_preset_zero();
    test_alarm_abort();
    test_load_drop();
    test_held_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
